// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch with credit-limited in-order requests,
//            response fetch queue and the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter int               FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_targetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD
);

  localparam int              c_PW    = $clog2(FQ_DEPTH);
  localparam int              c_CW    = c_PW + 1;
  localparam logic [c_CW:0]   c_DEPTH = FQ_DEPTH[c_CW:0];
  localparam logic [31:0]     c_NOP   = 32'h0000_0013;
  localparam logic [XLEN-1:0] c_FOUR  = XLEN'(4);

  logic [XLEN-1:0] r_pcF;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_kill;

  logic [XLEN-1:0] r_pcFifo [FQ_DEPTH];
  logic [c_PW-1:0] r_pfWr;
  logic [c_PW-1:0] r_pfRd;

  logic [31:0]     r_fqInstr [FQ_DEPTH];
  logic [XLEN-1:0] r_fqPc    [FQ_DEPTH];
  logic [c_PW-1:0] r_fqWr;
  logic [c_PW-1:0] r_fqRd;
  logic [c_CW-1:0] r_fqCount;

  logic [31:0]     r_instrD;
  logic [XLEN-1:0] r_pcD;
  logic [XLEN-1:0] r_pcPlus4D;
  logic            r_validD;

  logic [c_CW:0]   w_inUse;
  logic            w_reqValid;
  logic            w_accept;
  logic            w_killRsp;
  logic            w_push;
  logic            w_pop;
  logic [c_CW-1:0] w_acceptInc;
  logic [c_CW-1:0] w_rspDec;
  logic [c_CW-1:0] w_pushInc;
  logic [c_CW-1:0] w_popDec;

  // Killed in-flight requests still hold credit until their response drains.
  assign w_inUse     = {1'b0, r_outstanding} + {1'b0, r_fqCount};
  assign w_reqValid  = rst_n & ~pc_sel & ~stallF & (w_inUse < c_DEPTH);
  assign w_accept    = w_reqValid & imem_req_ready;
  assign w_killRsp   = imem_rsp_valid & (r_kill != '0);
  assign w_push      = imem_rsp_valid & (r_kill == '0) & ~pc_sel;
  assign w_pop       = ~stallD & ~flushD & (r_fqCount != '0);

  assign w_acceptInc = {{(c_CW-1){1'b0}}, w_accept};
  assign w_rspDec    = {{(c_CW-1){1'b0}}, imem_rsp_valid};
  assign w_pushInc   = {{(c_CW-1){1'b0}}, w_push};
  assign w_popDec    = {{(c_CW-1){1'b0}}, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcF         <= RESET_PC;
      r_outstanding <= '0;
      r_kill        <= '0;
      r_pfWr        <= '0;
      r_pfRd        <= '0;
    end else begin
      if (pc_sel) begin
        r_pcF <= pc_targetE;
      end else if (w_accept) begin
        r_pcF <= r_pcF + c_FOUR;
      end
      r_outstanding <= r_outstanding + w_acceptInc - w_rspDec;
      // Everything still in flight after this cycle is on the squashed path;
      // r_kill never exceeds r_outstanding, so earlier kills are included.
      if (pc_sel) begin
        r_kill <= r_outstanding - w_rspDec;
      end else if (w_killRsp) begin
        r_kill <= r_kill - 1'b1;
      end
      if (w_accept) begin
        r_pfWr <= r_pfWr + 1'b1;
      end
      if (imem_rsp_valid) begin
        r_pfRd <= r_pfRd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pcFifo[r_pfWr] <= r_pcF;
    end
    if (w_push) begin
      r_fqInstr[r_fqWr] <= imem_rsp_data;
      r_fqPc[r_fqWr]    <= r_pcFifo[r_pfRd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fqWr    <= '0;
      r_fqRd    <= '0;
      r_fqCount <= '0;
    end else if (pc_sel) begin
      r_fqWr    <= '0;
      r_fqRd    <= '0;
      r_fqCount <= '0;
    end else begin
      if (w_push) begin
        r_fqWr <= r_fqWr + 1'b1;
      end
      if (w_pop) begin
        r_fqRd <= r_fqRd + 1'b1;
      end
      r_fqCount <= r_fqCount + w_pushInc - w_popDec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrD   <= c_NOP;
      r_pcD      <= '0;
      r_pcPlus4D <= '0;
      r_validD   <= 1'b0;
    end else if (flushD) begin
      r_instrD <= c_NOP;
      r_validD <= 1'b0;
    end else if (!stallD) begin
      if (r_fqCount != '0) begin
        r_instrD   <= r_fqInstr[r_fqRd];
        r_pcD      <= r_fqPc[r_fqRd];
        r_pcPlus4D <= r_fqPc[r_fqRd] + c_FOUR;
        r_validD   <= 1'b1;
      end else begin
        r_instrD <= c_NOP;
        r_validD <= 1'b0;
      end
    end
  end

  assign imem_req_valid = w_reqValid;
  assign imem_req_addr  = r_pcF;
  assign instrD         = r_instrD;
  assign pcD            = r_pcD;
  assign pc_plus4D      = r_pcPlus4D;
  assign validD         = r_validD;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage with a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stallF, stallD, flushD, pc_sel;
  logic [31:0] pc_targetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD;

  int errors = 0;
  int checks = 0;
  int memLat = 1;
  bit monLoad;

  typedef struct {
    logic [31:0] addr;
    int          age;
  } memEnt_t;

  memEnt_t     memQ[$];
  logic [31:0] expQ[$];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .pc_sel(pc_sel), .pc_targetE(pc_targetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instrD(instrD), .pcD(pcD),
    .pc_plus4D(pc_plus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic waitValid(input string name, input int bound);
    int n = 0;
    while (!validD && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!validD) begin
      checks++;
      errors++;
      $display("FAIL %s: validD never rose within %0d cycles", name, bound);
    end
  endtask

  // Memory model: records accepts just before the edge, answers after it.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      memQ.push_back('{addr: imem_req_addr, age: 0});
    end
    if (!rst_n) begin
      memQ.delete();
      expQ.delete();
    end else if (pc_sel) begin
      expQ.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      expQ.push_back(imem_req_addr);
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (rst_n) begin
      foreach (memQ[i]) memQ[i].age++;
      if (memQ.size() > 0 && memQ[0].age >= memLat) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memData(memQ[0].addr);
        void'(memQ.pop_front());
      end
    end
  end

  // Monitor: compares every instruction newly loaded into decode.
  always begin
    @(negedge clk);
    #4;
    monLoad = rst_n && !stallD && !flushD;
    @(posedge clk);
    #1;
    if (monLoad && rst_n && validD) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL decode_extra: got pcD %h, expected no instruction", pcD);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        chk("decode_pc", pcD, e);
        chk("decode_instr", instrD, memData(e));
        chk("decode_pc4", pc_plus4D, e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] capPc, capInstr, capAddr;
    rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    pc_sel = 1'b0; pc_targetE = 32'h0; imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_instrD", instrD, c_NOP);
    chk("reset_validD", validD, 0);
    chk("reset_pcD", pcD, 0);
    chk("reset_pc4", pc_plus4D, 0);
    chk("reset_req_valid", imem_req_valid, 0);

    rst_n = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    @(negedge clk); chk("lat_cycle1_validD", validD, 0);
    @(negedge clk); chk("lat_cycle2_validD", validD, 0);
    @(negedge clk); chk("lat_cycle3_validD", validD, 1);
    chk("lat_first_pcD", pcD, 32'h0);
    repeat (15) @(negedge clk);

    // Decode stall: IF/ID frozen, queue fills, requests stop.
    stallD = 1'b1;
    capPc = pcD;
    capInstr = instrD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pcD", pcD, capPc);
      chk("stall_instrD", instrD, capInstr);
    end
    chk("stall_req_blocked", imem_req_valid, 0);
    stallD = 1'b0;
    repeat (10) @(negedge clk);

    // Redirect with two requests in flight on a 3-cycle memory.
    memLat = 3;
    begin
      int n = 0;
      while (!(memQ.size() == 2 && !imem_rsp_valid) && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("redir_two_inflight", memQ.size(), 2);
    end
    pc_sel = 1'b1; flushD = 1'b1; stallF = 1'b1; pc_targetE = 32'h100;
    @(negedge clk);
    pc_sel = 1'b0; flushD = 1'b0; stallF = 1'b0;
    chk("redir_validD", validD, 0);
    chk("redir_instrD", instrD, c_NOP);
    chk("redir_addr", imem_req_addr, 32'h100);
    waitValid("redir_first", 40);
    chk("redir_first_pcD", pcD, 32'h100);
    repeat (10) @(negedge clk);

    // Redirect coinciding with a response.
    memLat = 1;
    repeat (4) @(negedge clk);
    begin
      int n = 0;
      while (!imem_rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rr_rsp_seen", imem_rsp_valid, 1);
    end
    pc_sel = 1'b1; flushD = 1'b1; pc_targetE = 32'h200;
    @(negedge clk);
    pc_sel = 1'b0; flushD = 1'b0;
    chk("rr_validD", validD, 0);
    chk("rr_instrD", instrD, c_NOP);
    waitValid("rr_first", 40);
    chk("rr_first_pcD", pcD, 32'h200);
    repeat (8) @(negedge clk);

    // Memory not ready: PC holds, decode drains to bubbles.
    imem_req_ready = 1'b0;
    capAddr = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nready_addr", imem_req_addr, capAddr);
    end
    chk("nready_validD", validD, 0);
    chk("nready_instrD", instrD, c_NOP);
    chk("nready_drained", expQ.size(), 0);
    imem_req_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Mid-stream reset pulse.
    rst_n = 1'b0;
    #1;
    chk("mrst_validD", validD, 0);
    chk("mrst_instrD", instrD, c_NOP);
    chk("mrst_pcD", pcD, 0);
    chk("mrst_pc4", pc_plus4D, 0);
    chk("mrst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_restart_addr", imem_req_addr, 32'h0);
    waitValid("mrst_first", 10);
    chk("mrst_first_pcD", pcD, 32'h0);
    repeat (12) @(negedge clk);

    imem_req_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("final_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
